// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the SPU data-memory port arbiter: requester ids, FSM states,
// the default DMA starvation limit and the saturating counter helper.
package spu_mem_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_DM   = 2'd1,
        REQ_IF   = 2'd2,
        REQ_DMA  = 2'd3
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int STARVE_MAX_DEF = 8;

    function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
        if (val >= lim) begin
            return lim;
        end else begin
            return val + 4'd1;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the data-memory port arbiter.
// The arbiter uses the slave view; requesters and memory model use the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dm_done;
    logic          if_done;
    logic          dma_done;
    logic [DW-1:0] rsp_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    logic          busy;
    logic [1:0]    gnt_id;

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, if_req, if_addr,
               dma_req, dma_we, dma_addr, dma_wdata, mem_rdata, mem_done,
        output dm_done, if_done, dma_done, rsp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_id
    );

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, if_req, if_addr,
               dma_req, dma_we, dma_addr, dma_wdata, mem_rdata, mem_done,
        input  dm_done, if_done, dma_done, rsp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_id
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner selection for the memory port: DM > IF > DMA, with DMA promoted to
// the top when it has been starved.
module mem_arb_pick
    import spu_mem_pkg::*;
(
    input  logic    dm_req,
    input  logic    if_req,
    input  logic    dma_req,
    input  logic    force_dma,
    output req_id_e win_id
);

    // Priority decode of the pending requests
    always_comb begin
        win_id = REQ_NONE;
        if (force_dma && dma_req) begin
            win_id = REQ_DMA;
        end else if (dm_req) begin
            win_id = REQ_DM;
        end else if (if_req) begin
            win_id = REQ_IF;
        end else if (dma_req) begin
            win_id = REQ_DMA;
        end else begin
            win_id = REQ_NONE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port among CPU data, CPU fetch and SPU DMA.
// One transaction in flight at a time; every output comes straight from a register.
module mem_port_arbiter
    import spu_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              srst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e    state_r;
    req_id_e       gnt_id_r;
    req_id_e       win_id_s;
    logic [3:0]    starve_cnt_r;
    logic          mem_en_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic [DW-1:0] rsp_rdata_r;
    logic          busy_r;
    logic          dm_done_r;
    logic          if_done_r;
    logic          dma_done_r;
    logic          force_dma_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    assign force_dma_s = bus.dma_req && (starve_cnt_r == STARVE_LIM);

    mem_arb_pick u_pick (
        .dm_req    (bus.dm_req),
        .if_req    (bus.if_req),
        .dma_req   (bus.dma_req),
        .force_dma (force_dma_s),
        .win_id    (win_id_s)
    );

    // Transaction fields of the current winner; fetches are always reads
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        case (win_id_s)
            REQ_DM: begin
                sel_we_s    = bus.dm_we;
                sel_addr_s  = bus.dm_addr;
                sel_wdata_s = bus.dm_wdata;
            end
            REQ_IF: begin
                sel_addr_s  = bus.if_addr;
            end
            REQ_DMA: begin
                sel_we_s    = bus.dma_we;
                sel_addr_s  = bus.dma_addr;
                sel_wdata_s = bus.dma_wdata;
            end
            default: begin
                sel_we_s    = 1'b0;
            end
        endcase
    end

    // Arbiter FSM, starvation counter and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            gnt_id_r     <= REQ_NONE;
            starve_cnt_r <= 4'd0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            rsp_rdata_r  <= '0;
            busy_r       <= 1'b0;
            dm_done_r    <= 1'b0;
            if_done_r    <= 1'b0;
            dma_done_r   <= 1'b0;
        end else if (srst) begin
            state_r      <= ST_IDLE;
            gnt_id_r     <= REQ_NONE;
            starve_cnt_r <= 4'd0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            rsp_rdata_r  <= '0;
            busy_r       <= 1'b0;
            dm_done_r    <= 1'b0;
            if_done_r    <= 1'b0;
            dma_done_r   <= 1'b0;
        end else begin
            mem_en_r   <= 1'b0;
            dm_done_r  <= 1'b0;
            if_done_r  <= 1'b0;
            dma_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_id_s != REQ_NONE) begin
                        state_r     <= ST_ISSUE;
                        busy_r      <= 1'b1;
                        gnt_id_r    <= win_id_s;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= sel_we_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        if ((win_id_s == REQ_DMA) || !bus.dma_req) begin
                            starve_cnt_r <= 4'd0;
                        end else begin
                            starve_cnt_r <= sat_inc4(starve_cnt_r, STARVE_LIM);
                        end
                    end else begin
                        starve_cnt_r <= 4'd0;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mem_done) begin
                        state_r <= ST_RESP;
                        if (!mem_we_r) begin
                            rsp_rdata_r <= bus.mem_rdata;
                        end else begin
                            rsp_rdata_r <= rsp_rdata_r;
                        end
                        case (gnt_id_r)
                            REQ_DM:  dm_done_r  <= 1'b1;
                            REQ_IF:  if_done_r  <= 1'b1;
                            REQ_DMA: dma_done_r <= 1'b1;
                            default: dm_done_r  <= 1'b0;
                        endcase
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    gnt_id_r <= REQ_NONE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    gnt_id_r <= REQ_NONE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.busy      = busy_r;
    assign bus.gnt_id    = gnt_id_r;
    assign bus.dm_done   = dm_done_r;
    assign bus.if_done   = if_done_r;
    assign bus.dma_done  = dma_done_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters and a latency-programmable
// memory model; expected transactions are queued at drive time and retired on done.
module tb_mem_port_arbiter;
    import spu_mem_pkg::*;

    typedef struct {
        logic [1:0]  id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic clk;
    logic rst;
    logic srst;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .srst (srst),
        .bus  (bus)
    );

    txn_t        exp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_rsp;
    logic [31:0] mem_rd_next;
    logic        force_done;
    logic [2:0]  done_vec;
    txn_t        cur;
    int          mem_lat;
    int          mem_cnt;
    int          cyc;
    int          n_checks;
    int          n_pass;
    int          req_cyc;
    int          issue_cyc;
    int          done_cyc [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a;
    endfunction

    task automatic push_txn(input logic [1:0] id, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        txn_t t;
        t.id    = id;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = we ? 32'd0 : mem_rd(addr);
        exp_q.push_back(t);
    endtask

    // Hold requests until each requester has seen its quota of done pulses
    task automatic service(input int n_dm, input int n_if, input int n_dma, input int budget);
        while ((bus.dm_req || bus.if_req || bus.dma_req) && (budget > 0)) begin
            @(negedge clk);
            budget = budget - 1;
            if (bus.dm_done) begin
                n_dm = n_dm - 1;
                if (n_dm <= 0) bus.dm_req = 1'b0;
            end
            if (bus.if_done) begin
                n_if = n_if - 1;
                if (n_if <= 0) bus.if_req = 1'b0;
            end
            if (bus.dma_done) begin
                n_dma = n_dma - 1;
                if (n_dma <= 0) bus.dma_req = 1'b0;
            end
        end
        check_val("reqs_served", 32'({bus.dma_req, bus.if_req, bus.dm_req}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers each issue after mem_lat cycles, abandons work on reset
    always @(negedge clk) begin
        bus.mem_done = 1'b0;
        if (!rst) begin
            mem_cnt = 0;
        end else begin
            if (force_done) begin
                bus.mem_done  = 1'b1;
                bus.mem_rdata = 32'hFFFF_FFFF;
            end
            if (mem_cnt != 0) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    bus.mem_done  = 1'b1;
                    bus.mem_rdata = mem_rd_next;
                end
            end
            if (bus.mem_en) begin
                mem_cnt = mem_lat;
                if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
                mem_rd_next = mem_rd(bus.mem_addr);
            end
        end
    end

    // Scoreboard: compare issues against the queue head, retire on done
    always @(negedge clk) begin
        if (rst) begin
            if (bus.mem_en) begin
                issue_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_val("issue_unexpected", 32'd1, 32'd0);
                end else begin
                    check_val("gnt_id", 32'(bus.gnt_id), 32'(exp_q[0].id));
                    check_val("mem_we", 32'(bus.mem_we), 32'(exp_q[0].we));
                    check_val("mem_addr", bus.mem_addr, exp_q[0].addr);
                    if (exp_q[0].we) check_val("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
                end
            end
            done_vec = {bus.dma_done, bus.if_done, bus.dm_done};
            if (done_vec != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check_val("done_unexpected", 32'(done_vec), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    done_cyc[cur.id] = cyc;
                    if (!cur.we) exp_rsp = cur.rdata;
                    check_val("done_vec", 32'(done_vec), 32'(3'b001 << (cur.id - 2'd1)));
                    check_val("rsp_rdata", bus.rsp_rdata, exp_rsp);
                    check_val("gnt_at_done", 32'(bus.gnt_id), 32'(cur.id));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        srst          = 1'b0;
        force_done    = 1'b0;
        mem_lat       = 1;
        exp_rsp       = 32'd0;
        mem_rd_next   = 32'd0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'd0;
        bus.dm_wdata  = 32'd0;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = 32'd0;
        bus.dma_wdata = 32'd0;
        mem_model[32'h0000_0040] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_gnt", 32'(bus.gnt_id), 32'd0);
        check_val("rst_mem", 32'({bus.mem_en, bus.mem_we}), 32'd0);
        check_val("rst_addr", bus.mem_addr, 32'd0);
        check_val("rst_rsp", bus.rsp_rdata, 32'd0);
        check_val("rst_done", 32'({bus.dma_done, bus.if_done, bus.dm_done}), 32'd0);
        rst = 1'b1;

        // DM write, L=2: issue at cycle 1, done at cycle 4
        mem_lat = 2;
        @(posedge clk);
        #1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h0000_0100;
        bus.dm_wdata = 32'hDEAD_BEEF;
        bus.dm_req   = 1'b1;
        req_cyc      = cyc;
        push_txn(2'd1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        service(1, 0, 0, 40);
        check_val("t1_issue_lat", 32'(issue_cyc - req_cyc), 32'd1);
        check_val("t1_done_lat", 32'(done_cyc[1] - req_cyc), 32'd4);
        check_val("t1_rsp_hold", bus.rsp_rdata, 32'd0);
        check_val("t1_mem_write", mem_model[32'h0000_0100], 32'hDEAD_BEEF);

        // Simultaneous DM and IF reads, L=1: DM first, IF done 4 cycles later
        mem_lat = 1;
        @(posedge clk);
        #1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h0000_0200;
        bus.if_addr = 32'h0000_0080;
        bus.dm_req  = 1'b1;
        bus.if_req  = 1'b1;
        push_txn(2'd1, 1'b0, 32'h0000_0200, 32'd0);
        push_txn(2'd2, 1'b0, 32'h0000_0080, 32'd0);
        service(1, 1, 0, 60);
        check_val("t2_if_after_dm", 32'(done_cyc[2] - done_cyc[1]), 32'd4);

        // DMA starvation: forced on the ninth arbitration, then counter restarts
        @(posedge clk);
        #1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'h0000_0300;
        bus.dma_wdata = 32'hCAFE_F00D;
        bus.dm_req    = 1'b1;
        bus.dma_req   = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) push_txn(2'd1, 1'b0, 32'h0000_0200, 32'd0);
            push_txn(2'd3, 1'b1, 32'h0000_0300, 32'hCAFE_F00D);
        end
        service(16, 0, 2, 400);
        check_val("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // IF read returns fixed data, held through a following DMA write
        @(posedge clk);
        #1;
        bus.if_addr = 32'h0000_0040;
        bus.if_req  = 1'b1;
        push_txn(2'd2, 1'b0, 32'h0000_0040, 32'd0);
        service(0, 1, 0, 40);
        check_val("t4_if_rdata", bus.rsp_rdata, 32'h1234_5678);
        bus.dma_addr  = 32'h0000_0044;
        bus.dma_wdata = 32'h0BAD_F00D;
        bus.dma_req   = 1'b1;
        push_txn(2'd3, 1'b1, 32'h0000_0044, 32'h0BAD_F00D);
        service(0, 0, 1, 40);
        check_val("t4_rsp_held", bus.rsp_rdata, 32'h1234_5678);
        check_val("t4_dma_write", mem_model[32'h0000_0044], 32'h0BAD_F00D);

        // Reset in WAIT, then a spurious mem_done that must be ignored
        mem_lat = 6;
        @(posedge clk);
        #1;
        bus.dm_addr = 32'h0000_0500;
        bus.dm_req  = 1'b1;
        push_txn(2'd1, 1'b0, 32'h0000_0500, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("t5_in_wait", 32'({bus.busy, bus.gnt_id}), 32'({1'b1, 2'd1}));
        rst = 1'b0;
        #1;
        check_val("t5_rst_busy", 32'(bus.busy), 32'd0);
        check_val("t5_rst_gnt", 32'(bus.gnt_id), 32'd0);
        check_val("t5_rst_rsp", bus.rsp_rdata, 32'd0);
        check_val("t5_rst_mem", 32'({bus.mem_en, bus.dma_done, bus.if_done, bus.dm_done}), 32'd0);
        exp_q.delete();
        exp_rsp    = 32'd0;
        bus.dm_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b1;
        force_done = 1'b1;
        @(posedge clk);
        #1;
        force_done = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_val("t5_idle_busy", 32'(bus.busy), 32'd0);
        check_val("t5_idle_gnt", 32'(bus.gnt_id), 32'd0);
        check_val("t5_idle_rsp", bus.rsp_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
